// File: rtl/wallace_mul_pipe.sv
// wallace_mul_pipe
// Three-stage pipelined Wallace-tree multiplier. Each transaction carries its
// own signed/unsigned mode. Valid/ready handshakes on input and output share
// one advance enable, so a stalled consumer freezes the whole pipe.
//
//   S0: operands, mode, valid
//   S1: carry-save sum and carry rows (2*WIDTH bits each), valid
//   S2: final product, valid
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand transaction offered
//   in_ready   transaction accepted this cycle (depends only on out side)
//   in_a       multiplicand, WIDTH bits
//   in_b       multiplier, WIDTH bits
//   in_signed  1: two's-complement operands, 0: unsigned
//   out_valid  product available
//   out_ready  consumer takes the product this cycle
//   out_p      product, 2*WIDTH bits
module wallace_mul_pipe #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int PW    = 2 * WIDTH;
  // WIDTH partial-product rows plus one row for the Baugh-Wooley constants.
  localparam int NROWS = WIDTH + 1;
  localparam int NGRP  = (PW + 3) / 4;

  // Row count after one 3:2 layer: each full triple becomes two rows,
  // leftover rows pass straight through.
  function automatic int next_rows(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_at(input int layer);
    int n;
    n = NROWS;
    for (int l = 0; l < layer; l++) n = next_rows(n);
    return n;
  endfunction

  function automatic int count_layers(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = next_rows(n);
      l++;
    end
    return l;
  endfunction

  localparam int NLAYERS = count_layers(NROWS);

  // Combined {generate, propagate} over bit range [lo, hi). Empty range
  // gives {0, 1}, i.e. the carry-in passes through unchanged.
  function automatic logic [1:0] gp_range(input logic [PW-1:0] g,
                                          input logic [PW-1:0] p,
                                          input int lo, input int hi);
    logic gg;
    logic pp;
    gg = 1'b0;
    pp = 1'b1;
    for (int k = 0; k < PW; k++) begin
      if (k >= lo && k < hi) begin
        gg = g[k] | (p[k] & gg);
        pp = pp & p[k];
      end
    end
    return {gg, pp};
  endfunction

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sgn_reg, v0_reg;
  logic [PW-1:0]    sum_reg, carry_reg;
  logic             v1_reg;
  logic [PW-1:0]    p_reg;
  logic             v2_reg;
  logic             en;

  assign en        = !v2_reg || out_ready;
  assign in_ready  = en;
  assign out_valid = v2_reg;
  assign out_p     = p_reg;

  // ---------------------------------------------------------------------
  // Partial products and carry-save reduction tree
  // ---------------------------------------------------------------------
  logic [PW-1:0] tree [0:NLAYERS][0:NROWS-1];

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      logic [WIDTH-1:0] pp_bits;
      for (gj = 0; gj < WIDTH; gj++) begin : g_bit
        // Baugh-Wooley: terms pairing exactly one operand MSB carry negative
        // weight, so they are inverted in signed mode.
        if ((gi == WIDTH - 1) != (gj == WIDTH - 1)) begin : g_cross
          assign pp_bits[gj] = (a_reg[gj] & b_reg[gi]) ^ sgn_reg;
        end else begin : g_plain
          assign pp_bits[gj] = a_reg[gj] & b_reg[gi];
        end
      end
      assign tree[0][gi] = PW'(pp_bits) << gi;
    end
  endgenerate

  // Correction ones at bit WIDTH and bit 2*WIDTH-1 complete the signed form.
  assign tree[0][WIDTH] = sgn_reg ? ((PW'(1) << WIDTH) | (PW'(1) << (PW - 1)))
                                  : '0;

  generate
    for (gi = 0; gi < NLAYERS; gi++) begin : g_layer
      localparam int N    = rows_at(gi);
      localparam int NG   = N / 3;
      localparam int NREM = N % 3;
      localparam int NN   = next_rows(N);
      for (gj = 0; gj < NG; gj++) begin : g_csa
        logic [PW-1:0] x, y, z;
        assign x = tree[gi][3*gj];
        assign y = tree[gi][3*gj+1];
        assign z = tree[gi][3*gj+2];
        assign tree[gi+1][2*gj]   = x ^ y ^ z;
        // Carry out of the top bit is beyond the product width.
        assign tree[gi+1][2*gj+1] = ((x & y) | (x & z) | (y & z)) << 1;
      end
      for (gj = 0; gj < NREM; gj++) begin : g_pass
        assign tree[gi+1][2*NG+gj] = tree[gi][3*NG+gj];
      end
      for (gj = NN; gj < NROWS; gj++) begin : g_zero
        assign tree[gi+1][gj] = '0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Final carry-lookahead adder: 4-bit groups, group carries from a
  // lookahead over group generate/propagate, bit carries from the prefix
  // inside each group.
  // ---------------------------------------------------------------------
  logic [PW-1:0]   fa_g, fa_p, fa_s;
  logic [NGRP-1:0] grp_g, grp_p, gcin;

  assign fa_g = sum_reg & carry_reg;
  assign fa_p = sum_reg ^ carry_reg;

  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      localparam int LO = 4 * gi;
      localparam int HI = (4 * gi + 4 > PW) ? PW : 4 * gi + 4;
      logic [1:0] gp_grp;
      logic [1:0] gp_in;
      assign gp_grp    = gp_range(fa_g, fa_p, LO, HI);
      assign grp_g[gi] = gp_grp[1];
      assign grp_p[gi] = gp_grp[0];
      assign gp_in     = gp_range(PW'(grp_g), PW'(grp_p), 0, gi);
      assign gcin[gi]  = gp_in[1];
    end

    for (gi = 0; gi < PW; gi++) begin : g_sum
      localparam int GB = (gi / 4) * 4;
      logic [1:0] gp_b;
      assign gp_b      = gp_range(fa_g, fa_p, GB, gi);
      assign fa_s[gi]  = fa_p[gi] ^ (gp_b[1] | (gp_b[0] & gcin[gi/4]));
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Stage registers: all advance together on en, all hold otherwise.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      v0_reg    <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= '0;
      v1_reg    <= 1'b0;
      p_reg     <= '0;
      v2_reg    <= 1'b0;
    end else if (en) begin
      a_reg     <= in_a;
      b_reg     <= in_b;
      sgn_reg   <= in_signed;
      v0_reg    <= in_valid;
      sum_reg   <= tree[NLAYERS][0];
      carry_reg <= tree[NLAYERS][1];
      v1_reg    <= v0_reg;
      p_reg     <= fa_s;
      v2_reg    <= v1_reg;
    end
  end

endmodule
